// File: rtl/bkm_slot_pkg.sv
// bkm_slot_pkg: command codes, register addresses, video values and FSM encoding for the BKM slot interface
package bkm_slot_pkg;

    typedef enum logic [1:0] {S_IDLE, S_REG, S_DATA, S_IRQ} state_t;

    localparam logic [7:0] CMD_IRQ    = 8'h02;
    localparam logic [7:0] CMD_INIT   = 8'h10;
    localparam logic [7:0] CMD_ID     = 8'h20;
    localparam logic [7:0] CMD_VIDEO  = 8'h21;
    localparam logic [7:0] CMD_PREP   = 8'h22;
    localparam logic [7:0] CMD_SERIAL = 8'h23;
    localparam logic [7:0] BYTE_SEL   = 8'hFF;

    localparam logic [7:0] REG_ID   = 8'h00;
    localparam logic [7:0] REG_INT  = 8'h41;
    localparam logic [7:0] REG_RGB  = 8'h00;
    localparam logic [7:0] REG_VOE  = 8'h10;
    localparam logic [7:0] REG_FMT  = 8'h31;
    localparam logic [7:0] REG_BUSY = 8'h27;
    localparam logic [5:0] REG_INIT_PAGE = 6'h10;
    localparam logic [4:0] REG_PREP_PAGE = 5'h04;

    localparam logic [7:0] VID_RGB    = 8'h04;
    localparam logic [7:0] VID_OE_INT = 8'h08;
    localparam logic [7:0] VID_OE_EXT = 8'h09;
    localparam logic [7:0] INT_CLR    = 8'h02;
    localparam logic [7:0] IRQ_OFF    = 8'h00;
    localparam logic [7:0] IRQ_ON     = 8'h01;

    function automatic logic fmt_is_hd(input logic [7:0] f);
        return f >= 8'd1 && f <= 8'd3;
    endfunction

endpackage

// File: rtl/bkm_bus_sync.sv
// bkm_bus_sync: two-flop synchronizer for the asynchronous slot bus plus clk_rw rising-edge detect
module bkm_bus_sync (
    input  logic       clk_20mhz,
    input  logic       reset,
    input  logic       clk_rw,
    input  logic       ax_d,
    input  logic       r_wx,
    input  logic       slot_x_int_x,
    input  logic [7:0] data_in,
    output logic       ax_d_s,
    output logic       r_wx_s,
    output logic       slot_s,
    output logic [7:0] data_s,
    output logic       xfer
);
    logic [11:0] meta, sync;
    logic rw_d;
    // all bus lines share the same two-stage delay so they stay aligned with the strobe
    always_ff @(posedge clk_20mhz) begin
        if (reset) begin
            meta <= '0;
            sync <= '0;
            rw_d <= 1'b0;
        end else begin
            meta <= {clk_rw, ax_d, r_wx, slot_x_int_x, data_in};
            sync <= meta;
            rw_d <= sync[11];
        end
    end
    assign {ax_d_s, r_wx_s, slot_s, data_s} = sync[10:0];
    assign xfer = sync[11] & ~rw_d;
endmodule

// File: rtl/bkm_slot_if.sv
// bkm_slot_if: option-slot bus target with init, video, prepare and identity register pages
module bkm_slot_if
    import bkm_slot_pkg::*;
#(
    parameter logic [7:0]              ID_CODE    = 8'h88,
    parameter int                      SERIAL_LEN = 7,
    parameter logic [SERIAL_LEN*8-1:0] SERIAL     = "2000555",
    parameter int                      BUSY_READS = 13
) (
    input  logic       clk_20mhz,
    input  logic       reset,
    input  logic       clk_rw,
    input  logic       ax_d,
    input  logic       r_wx,
    input  logic       slot_x_int_x,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe_x,
    output logic       int_x,
    output logic       int_oe_x,
    output logic       video_oe_x,
    output logic       rgb_comp_x,
    output logic       int_ext_x,
    output logic       hd_sd_x
);
    localparam logic [7:0] BUSY_LOAD = 8'(BUSY_READS);
    localparam logic [7:0] SER_LAST  = 8'(SERIAL_LEN);

    logic ax_s, rw_s, slot_s, xfer, sel, new_cmd, cmd_ok;
    logic [7:0] din, cmd, reg_a, fmt, busy_cnt, rd_val;
    logic [7:0] init_r [4];
    logic [7:0] prep [8];
    logic [SERIAL_LEN*8-1:0] ser_sh;
    state_t state;

    bkm_bus_sync u_sync (
        .clk_20mhz(clk_20mhz), .reset(reset), .clk_rw(clk_rw), .ax_d(ax_d), .r_wx(r_wx),
        .slot_x_int_x(slot_x_int_x), .data_in(data_in), .ax_d_s(ax_s), .r_wx_s(rw_s),
        .slot_s(slot_s), .data_s(din), .xfer(xfer)
    );

    // a command byte in S_DATA aborts the pending access and is decoded like one in S_IDLE
    assign new_cmd = xfer && !ax_s && (state == S_IDLE || state == S_DATA);
    assign cmd_ok  = (din == CMD_INIT && !slot_s) || (din >= CMD_ID && din <= CMD_SERIAL && sel);
    assign ser_sh  = SERIAL << {reg_a - 8'd1, 3'b000};
    assign hd_sd_x = !fmt_is_hd(fmt);

    // read mux for the current command page; prep[7] is the busy-status register 0x27
    always_comb begin
        rd_val = 8'hFF;
        if (cmd == CMD_INIT && reg_a[7:2] == REG_INIT_PAGE)
            rd_val = init_r[reg_a[1:0]];
        else if ((cmd == CMD_ID || cmd == CMD_SERIAL) && reg_a == REG_ID)
            rd_val = ID_CODE;
        else if (cmd == CMD_VIDEO && reg_a == REG_FMT)
            rd_val = fmt;
        else if (cmd == CMD_PREP && reg_a[7:3] == REG_PREP_PAGE)
            rd_val = reg_a == REG_BUSY ? (busy_cnt > 8'd1 ? prep[7] : 8'h00) : prep[reg_a[2:0]];
        else if (cmd == CMD_SERIAL && reg_a <= SER_LAST)
            rd_val = ser_sh[SERIAL_LEN*8-1 -: 8];
    end

    // protocol FSM with all register side effects; the slot-number write (0x03) has no consumer and is dropped
    always_ff @(posedge clk_20mhz) begin
        if (reset) begin
            state      <= S_IDLE;
            sel        <= 1'b0;
            cmd        <= 8'h00;
            reg_a      <= 8'h00;
            data_out   <= 8'hFF;
            data_oe_x  <= 1'b1;
            int_x      <= 1'b0;
            int_oe_x   <= 1'b0;
            video_oe_x <= 1'b1;
            rgb_comp_x <= 1'b0;
            int_ext_x  <= 1'b0;
            fmt        <= 8'h00;
            busy_cnt   <= 8'h00;
            init_r     <= '{8'hFF, 8'hFD, 8'hFF, 8'hFD};
            prep       <= '{default: 8'h00};
        end else begin
            data_oe_x <= !(sel && state == S_DATA && rw_s && ax_s);
            if (state == S_DATA)
                data_out <= rd_val;
            if (new_cmd) begin
                state <= cmd_ok ? S_REG : din == CMD_IRQ ? S_IRQ : S_IDLE;
                if (cmd_ok)
                    cmd <= din;
                if (din == BYTE_SEL)
                    sel <= !sel;
            end else if (xfer) begin
                case (state)
                    S_REG: begin
                        reg_a <= din;
                        state <= S_DATA;
                    end
                    S_DATA: begin
                        state <= S_IDLE;
                        if (!rw_s) begin
                            if (cmd == CMD_INIT && reg_a == REG_INT && din == INT_CLR) begin
                                int_x     <= 1'b1;
                                init_r[1] <= 8'hFF;
                            end else if (cmd == CMD_INIT && reg_a[7:2] == REG_INIT_PAGE)
                                init_r[reg_a[1:0]] <= din;
                            if (cmd == CMD_VIDEO && reg_a == REG_RGB)
                                rgb_comp_x <= din != VID_RGB;
                            if (cmd == CMD_VIDEO && reg_a == REG_VOE) begin
                                video_oe_x <= din != VID_OE_INT && din != VID_OE_EXT;
                                int_ext_x  <= din == VID_OE_INT ? 1'b0 : din == VID_OE_EXT ? 1'b1 : int_ext_x;
                            end
                            if (cmd == CMD_VIDEO && reg_a == REG_FMT)
                                fmt <= din;
                            if (cmd == CMD_PREP && reg_a[7:3] == REG_PREP_PAGE)
                                prep[reg_a[2:0]] <= din;
                            if (cmd == CMD_PREP && reg_a == REG_BUSY)
                                busy_cnt <= din != 8'h00 ? BUSY_LOAD : 8'h00;
                        end else if (cmd == CMD_PREP && reg_a == REG_BUSY) begin
                            busy_cnt <= busy_cnt > 8'd1 ? busy_cnt - 8'd1 : 8'h00;
                            if (busy_cnt <= 8'd1)
                                prep[7] <= 8'h00;
                        end
                    end
                    S_IRQ: begin
                        if (din == IRQ_ON)
                            int_oe_x <= 1'b1;
                        else if (din == IRQ_OFF)
                            int_oe_x <= 1'b0;
                        else if (din == BYTE_SEL) begin
                            state <= S_IDLE;
                            if (!int_oe_x)
                                sel <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bkm_slot_if.sv
// tb_bkm_slot_if: directed bus transactions checked against a transaction-level model of the slot interface
module tb_bkm_slot_if;
    logic clk_20mhz = 1'b0, reset = 1'b1, clk_rw = 1'b0, ax_d = 1'b0, r_wx = 1'b0, slot_x_int_x = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic data_oe_x, int_x, int_oe_x, video_oe_x, rgb_comp_x, int_ext_x, hd_sd_x;
    int total = 0, bad = 0;
    bit settled = 1'b0;

    localparam int P_IDLE = 0, P_REG = 1, P_DATA = 2, P_IRQ = 3;
    localparam int BUSY = 13;
    int m_ph, m_busy;
    bit m_sel, m_int_x, m_int_oe, m_voe, m_rgb, m_ext;
    logic [7:0] m_cmd, m_reg, m_fmt, m_dout;
    logic [7:0] m_init [4];
    logic [7:0] m_prep [8];
    logic [7:0] ser [7] = '{8'h32, 8'h30, 8'h30, 8'h30, 8'h35, 8'h35, 8'h35};
    logic [7:0] ser_tbl [9] = '{8'h88, 8'h32, 8'h30, 8'h30, 8'h30, 8'h35, 8'h35, 8'h35, 8'hFF};

    bkm_slot_if dut (
        .clk_20mhz(clk_20mhz), .reset(reset), .clk_rw(clk_rw), .ax_d(ax_d), .r_wx(r_wx),
        .slot_x_int_x(slot_x_int_x), .data_in(data_in), .data_out(data_out), .data_oe_x(data_oe_x),
        .int_x(int_x), .int_oe_x(int_oe_x), .video_oe_x(video_oe_x), .rgb_comp_x(rgb_comp_x),
        .int_ext_x(int_ext_x), .hd_sd_x(hd_sd_x)
    );

    always #25 clk_20mhz = ~clk_20mhz;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_read();
        int r = int'(m_reg);
        if (m_cmd == 8'h10 && r >= 'h40 && r <= 'h43) return m_init[r - 'h40];
        if ((m_cmd == 8'h20 || m_cmd == 8'h23) && r == 0) return 8'h88;
        if (m_cmd == 8'h21 && r == 'h31) return m_fmt;
        if (m_cmd == 8'h22 && r >= 'h20 && r <= 'h26) return m_prep[r - 'h20];
        if (m_cmd == 8'h22 && r == 'h27) return m_busy > 1 ? m_prep[7] : 8'h00;
        if (m_cmd == 8'h23 && r >= 1 && r <= 7) return ser[r - 1];
        return 8'hFF;
    endfunction

    task automatic m_write(input logic [7:0] d);
        int r = int'(m_reg);
        if (m_cmd == 8'h10 && r == 'h41 && d == 8'h02) begin
            m_int_x = 1;
            m_init[1] = 8'hFF;
        end else if (m_cmd == 8'h10 && r >= 'h40 && r <= 'h43)
            m_init[r - 'h40] = d;
        if (m_cmd == 8'h21 && r == 'h00) m_rgb = d != 8'h04;
        if (m_cmd == 8'h21 && r == 'h10) begin
            if (d == 8'h08) begin m_voe = 0; m_ext = 0; end
            else if (d == 8'h09) begin m_voe = 0; m_ext = 1; end
            else m_voe = 1;
        end
        if (m_cmd == 8'h21 && r == 'h31) m_fmt = d;
        if (m_cmd == 8'h22 && r >= 'h20 && r <= 'h27) begin
            m_prep[r - 'h20] = d;
            if (r == 'h27) m_busy = d != 8'h00 ? BUSY : 0;
        end
    endtask

    task automatic m_byte(input logic a, input logic rw, input logic [7:0] d);
        if (!a && (m_ph == P_IDLE || m_ph == P_DATA)) begin
            if ((d == 8'h10 && !slot_x_int_x) || (d >= 8'h20 && d <= 8'h23 && m_sel)) begin
                m_cmd = d;
                m_ph = P_REG;
            end else if (d == 8'h02) m_ph = P_IRQ;
            else begin
                m_ph = P_IDLE;
                if (d == 8'hFF) m_sel = !m_sel;
            end
        end else if (m_ph == P_REG) begin
            m_reg = d;
            m_ph = P_DATA;
            m_dout = m_read();
        end else if (m_ph == P_DATA) begin
            m_ph = P_IDLE;
            if (!rw) m_write(d);
            else if (m_cmd == 8'h22 && m_reg == 8'h27) begin
                if (m_busy > 1) m_busy--;
                else begin m_busy = 0; m_prep[7] = 8'h00; end
            end
        end else if (m_ph == P_IRQ) begin
            if (d == 8'h01) m_int_oe = 1;
            else if (d == 8'h00) m_int_oe = 0;
            else if (d == 8'hFF) begin
                m_ph = P_IDLE;
                if (!m_int_oe) m_sel = 0;
            end
        end
    endtask

    task automatic do_reset();
        settled = 0;
        reset = 1; clk_rw = 0; ax_d = 0; r_wx = 0; data_in = 8'h00;
        repeat (4) @(posedge clk_20mhz);
        reset = 0;
        m_ph = P_IDLE; m_sel = 0; m_int_x = 0; m_int_oe = 0; m_voe = 1; m_rgb = 0; m_ext = 0;
        m_fmt = 8'h00; m_busy = 0; m_dout = 8'hFF; m_cmd = 8'h00; m_reg = 8'h00;
        m_init = '{8'hFF, 8'hFD, 8'hFF, 8'hFD};
        m_prep = '{default: 8'h00};
        repeat (4) @(posedge clk_20mhz);
        settled = 1;
    endtask

    task automatic send(input logic a, input logic rw, input logic [7:0] d);
        settled = 0;
        ax_d = a; r_wx = rw; data_in = d;
        repeat (3) @(posedge clk_20mhz);
        clk_rw = 1;
        repeat (4) @(posedge clk_20mhz);
        m_byte(a, rw, d);
        clk_rw = 0;
        repeat (4) @(posedge clk_20mhz);
        settled = 1;
    endtask

    task automatic cb(input logic [7:0] d); send(1'b0, 1'b0, d); endtask
    task automatic wr(input logic [7:0] d); send(1'b1, 1'b0, d); endtask
    task automatic access(input logic [7:0] c, input logic [7:0] r); cb(c); cb(r); endtask

    task automatic rd(input string name, input logic [7:0] exp, input logic exp_oe = 1'b0);
        settled = 0;
        ax_d = 1; r_wx = 1;
        repeat (5) @(posedge clk_20mhz);
        settled = 1;
        @(negedge clk_20mhz);
        check(name, data_out, exp);
        check({name, "_oe"}, 8'(data_oe_x), 8'(exp_oe));
        send(1'b1, 1'b1, 8'h00);
    endtask

    // every settled cycle the outputs must equal the model
    always @(negedge clk_20mhz) begin
        if (settled) begin
            check("m_data_out", data_out, m_dout);
            check("m_data_oe_x", 8'(data_oe_x), 8'(!(m_sel && m_ph == P_DATA && r_wx && ax_d)));
            check("m_int_x", 8'(int_x), 8'(m_int_x));
            check("m_int_oe_x", 8'(int_oe_x), 8'(m_int_oe));
            check("m_video_oe_x", 8'(video_oe_x), 8'(m_voe));
            check("m_rgb_comp_x", 8'(rgb_comp_x), 8'(m_rgb));
            check("m_int_ext_x", 8'(int_ext_x), 8'(m_ext));
            check("m_hd_sd_x", 8'(hd_sd_x), 8'(!(m_fmt >= 8'd1 && m_fmt <= 8'd3)));
        end
    end

    initial begin
        repeat (100000) @(posedge clk_20mhz);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_data_out", data_out, 8'hFF);
        check("rst_data_oe_x", 8'(data_oe_x), 8'h01);
        check("rst_int_x", 8'(int_x), 8'h00);
        check("rst_int_oe_x", 8'(int_oe_x), 8'h00);
        check("rst_video_oe_x", 8'(video_oe_x), 8'h01);
        check("rst_rgb_comp_x", 8'(rgb_comp_x), 8'h00);
        check("rst_int_ext_x", 8'(int_ext_x), 8'h00);
        check("rst_hd_sd_x", 8'(hd_sd_x), 8'h01);

        cb(8'hFF);
        access(8'h20, 8'h00);
        check("id_oe_before", 8'(data_oe_x), 8'h01);
        rd("id_read", 8'h88);
        check("id_oe_after", 8'(data_oe_x), 8'h01);

        for (int i = 0; i < 9; i++) begin
            access(8'h23, 8'(i));
            rd("serial", ser_tbl[i]);
        end

        access(8'h22, 8'h27);
        wr(8'h09);
        for (int i = 0; i < 14; i++) begin
            access(8'h22, 8'h27);
            rd("busy_drain", i < 12 ? 8'h09 : 8'h00);
        end
        access(8'h22, 8'h27);
        wr(8'h09);
        for (int i = 0; i < 11; i++) begin
            access(8'h22, 8'h27);
            rd("busy_pre", 8'h09);
        end
        access(8'h22, 8'h27);
        wr(8'h07);
        for (int i = 0; i < 2; i++) begin
            access(8'h22, 8'h27);
            rd("busy_reload", 8'h07);
        end
        access(8'h22, 8'h27);
        wr(8'h00);
        access(8'h22, 8'h27);
        rd("busy_clear", 8'h00);

        access(8'h22, 8'h20);
        wr(8'hA5);
        access(8'h22, 8'h26);
        wr(8'h5A);
        access(8'h22, 8'h20);
        rd("prep20", 8'hA5);
        access(8'h22, 8'h26);
        rd("prep26", 8'h5A);

        access(8'h22, 8'h20);
        access(8'h21, 8'h31);
        wr(8'h02);
        check("fmt2_hd_sd_x", 8'(hd_sd_x), 8'h00);
        access(8'h22, 8'h20);
        rd("abort_nowrite", 8'hA5);
        access(8'h21, 8'h31);
        wr(8'h04);
        check("fmt4_hd_sd_x", 8'(hd_sd_x), 8'h01);
        access(8'h21, 8'h31);
        rd("fmt_read", 8'h04);
        access(8'h21, 8'h10);
        wr(8'h09);
        check("v09_video_oe_x", 8'(video_oe_x), 8'h00);
        check("v09_int_ext_x", 8'(int_ext_x), 8'h01);
        access(8'h21, 8'h10);
        wr(8'h08);
        check("v08_int_ext_x", 8'(int_ext_x), 8'h00);
        access(8'h21, 8'h10);
        wr(8'h00);
        check("v00_video_oe_x", 8'(video_oe_x), 8'h01);
        access(8'h21, 8'h00);
        wr(8'h04);
        check("rgb04", 8'(rgb_comp_x), 8'h00);
        access(8'h21, 8'h00);
        wr(8'h07);
        check("rgb07", 8'(rgb_comp_x), 8'h01);

        slot_x_int_x = 1;
        access(8'h10, 8'h41);
        wr(8'h02);
        check("init_ignored_int_x", 8'(int_x), 8'h00);
        slot_x_int_x = 0;
        access(8'h10, 8'h43);
        rd("init43_reset", 8'hFD);
        access(8'h10, 8'h41);
        wr(8'h02);
        check("init_int_x", 8'(int_x), 8'h01);
        access(8'h10, 8'h41);
        rd("init41", 8'hFF);
        access(8'h10, 8'h42);
        wr(8'h3C);
        access(8'h10, 8'h42);
        rd("init42", 8'h3C);

        cb(8'h02);
        cb(8'h01);
        check("irq_on", 8'(int_oe_x), 8'h01);
        cb(8'hFF);
        access(8'h20, 8'h00);
        rd("irq_still_sel", 8'h88);
        cb(8'h02);
        cb(8'h00);
        check("irq_off", 8'(int_oe_x), 8'h00);
        cb(8'hFF);
        access(8'h20, 8'h00);
        rd("desel_read", 8'h88, 1'b1);

        cb(8'hFF);
        access(8'h22, 8'h27);
        do_reset();
        check("rst2_int_x", 8'(int_x), 8'h00);
        check("rst2_data_out", data_out, 8'hFF);
        wr(8'h09);
        cb(8'hFF);
        access(8'h22, 8'h27);
        rd("reset_abort_busy", 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
